serial_word_recovery: RTL and testbench

SERIAL_WORD_RECOVERY -- requirements
Module: serial_word_recovery

---
 rtl/serial_word_recovery_pkg.sv | 18 +
 rtl/bit_sync.sv | 27 ++
 rtl/serial_word_recovery.sv | 138 +++++++++++++
 tb/tb_serial_word_recovery.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_word_recovery_pkg.sv
// Shared types and default constants for the serial word recovery block.
//   rx_state_e        : receiver FSM state encoding
//   DefaultWordW      : default recovered word width
//   DefaultOversample : default clock_50 cycles per serial bit
package serial_word_recovery_pkg;

    localparam int unsigned DefaultWordW      = 14;
    localparam int unsigned DefaultOversample = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clock_50 : destination clock
//   reset    : asynchronous active-high reset, both flops load RESET_VALUE
//   d        : asynchronous input
//   q        : synchronized output
module bit_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock_50,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_word_recovery.sv
// Oversampling serial receiver: start bit, WORD_W data bits LSB first, stop bit.
//   clock_50       : single clock, all state on its rising edge
//   reset          : asynchronous active-high reset
//   serial_in      : asynchronous serial line, idles high
//   data_rec       : last correctly framed word, changes only with clock_recovery
//   clock_recovery : one-cycle strobe, data_rec has just been updated
//   frame_error    : one-cycle strobe on a bad stop bit
//   busy           : FSM is outside IDLE
// data_rec/clock_recovery feed the downstream sampler directly, so both are
// plain registers. OVERSAMPLE must be even and at least 4.
module serial_word_recovery
    import serial_word_recovery_pkg::*;
#(
    parameter int unsigned WORD_W     = DefaultWordW,
    parameter int unsigned OVERSAMPLE = DefaultOversample
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              serial_in,
    output logic [WORD_W-1:0] data_rec,
    output logic              clock_recovery,
    output logic              frame_error,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE) + 1;
    localparam int unsigned IdxW = $clog2(WORD_W + 1);

    // Counter value on the edge that is a sample point.
    localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(WORD_W - 1);

    logic              rx;
    logic              rx_prev;
    rx_state_e         state;
    logic [CntW-1:0]   bit_cnt;
    logic [IdxW-1:0]   bit_idx;
    logic [WORD_W-1:0] shift_reg;
    logic              stop_done;
    logic              stop_bit;

    bit_sync #(
        .RESET_VALUE (1'b1)
    ) u_bit_sync (
        .clock_50 (clock_50),
        .reset    (reset),
        .d        (serial_in),
        .q        (rx)
    );

    assign busy = (state != StIdle);

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state          <= StIdle;
            rx_prev        <= 1'b1;
            bit_cnt        <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            stop_done      <= 1'b0;
            stop_bit       <= 1'b0;
            data_rec       <= '0;
            clock_recovery <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            rx_prev        <= rx;
            clock_recovery <= 1'b0;
            frame_error    <= 1'b0;

            case (state)
                StIdle: begin
                    if (rx_prev && !rx) begin
                        state   <= StStart;
                        bit_cnt <= '0;
                    end
                end

                // Re-check the start bit at its centre to reject glitches.
                StStart: begin
                    if (bit_cnt == HalfLast) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx ? StIdle : StData;
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end

                StData: begin
                    if (bit_cnt == BitLast) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx, shift_reg[WORD_W-1:1]};
                        if (bit_idx == IdxLast) begin
                            bit_idx <= '0;
                            state   <= StStop;
                        end else begin
                            bit_idx <= bit_idx + IdxW'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end

                // Sample the stop bit, then act on it one edge later.
                StStop: begin
                    if (stop_done) begin
                        stop_done <= 1'b0;
                        if (stop_bit) begin
                            data_rec       <= shift_reg;
                            clock_recovery <= 1'b1;
                            state          <= StIdle;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= StBreak;
                        end
                    end else if (bit_cnt == BitLast) begin
                        bit_cnt   <= '0;
                        stop_done <= 1'b1;
                        stop_bit  <= rx;
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end

                // Line held low: wait for it to return high before re-arming.
                StBreak: begin
                    if (rx) begin
                        state <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_recovery.sv
// Self-checking bench for serial_word_recovery with default parameters.
module tb_serial_word_recovery;

    logic        clock_50 = 1'b0;
    logic        reset;
    logic        serial_in;
    logic [13:0] data_rec;
    logic        clock_recovery;
    logic        frame_error;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic        good;
        logic [13:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [13:0] last_good = '0;
    logic [13:0] prev_data = '0;

    serial_word_recovery #(
        .WORD_W     (14),
        .OVERSAMPLE (16)
    ) dut (
        .clock_50       (clock_50),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_rec       (data_rec),
        .clock_recovery (clock_recovery),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    always #5 clock_50 = ~clock_50;

    always @(posedge clock_50) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 2 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock_50);
        #2;
    endtask

    // Full frame; strobe lands t0+249 where t0 is 3 edges after the start drive.
    task automatic send_frame(input logic [13:0] data, input logic stop);
        exp_t e;
        serial_in = 1'b0;
        e.cyc     = cyc + 252;
        if (stop) begin
            e.good    = 1'b1;
            e.data    = data;
            last_good = data;
        end else begin
            e.good = 1'b0;
            e.data = last_good;
        end
        exp_q.push_back(e);
        step(16);
        for (int i = 0; i < 14; i++) begin
            serial_in = data[i];
            step(16);
        end
        serial_in = stop;
        step(16);
    endtask

    // Strobe scoreboard plus the mutual-exclusion and data-hold invariants.
    always @(negedge clock_50) begin
        if (reset) begin
            prev_data = data_rec;
        end else begin
            check("strobe_exclusive", 32'(clock_recovery && frame_error), 32'(0));
            if (!clock_recovery) check("data_hold", 32'(data_rec), 32'(prev_data));
            prev_data = data_rec;
            if (clock_recovery || frame_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(cyc), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_kind", 32'(clock_recovery), 32'(mon_e.good));
                    check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("strobe_data", 32'(data_rec), 32'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        step(4);
        check("reset_data", 32'(data_rec), 32'(0));
        check("reset_cr", 32'(clock_recovery), 32'(0));
        check("reset_fe", 32'(frame_error), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        step(5);

        // Good frame
        send_frame(14'h2A5C, 1'b1);
        check("good_data", 32'(data_rec), 32'(14'h2A5C));
        check("good_drain", 32'(exp_q.size()), 32'(0));
        check("good_idle", 32'(busy), 32'(0));
        step(8);

        // Glitch: 4 low cycles
        serial_in = 1'b0;
        step(4);
        check("glitch_busy", 32'(busy), 32'(1));
        serial_in = 1'b1;
        step(12);
        check("glitch_idle", 32'(busy), 32'(0));
        check("glitch_data", 32'(data_rec), 32'(14'h2A5C));
        step(8);

        // Bad stop bit; line stays low afterwards
        send_frame(14'h1FFF, 1'b0);
        check("bad_drain", 32'(exp_q.size()), 32'(0));
        check("bad_data", 32'(data_rec), 32'(14'h2A5C));
        check("break_busy0", 32'(busy), 32'(1));
        step(20);
        check("break_busy1", 32'(busy), 32'(1));
        serial_in = 1'b1;
        step(4);
        check("break_release", 32'(busy), 32'(0));
        step(8);

        // Back-to-back frames
        send_frame(14'h0001, 1'b1);
        send_frame(14'h3FFE, 1'b1);
        check("b2b_data", 32'(data_rec), 32'(14'h3FFE));
        check("b2b_drain", 32'(exp_q.size()), 32'(0));
        step(8);

        // Reset during data bit 5 of 14'h0123
        serial_in = 1'b0;
        step(16);
        for (int i = 0; i < 5; i++) begin
            serial_in = (i == 0 || i == 1) ? 1'b1 : 1'b0;
            step(16);
        end
        serial_in = 1'b1;
        step(8);
        check("mid_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        step(3);
        check("rst_data", 32'(data_rec), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cr", 32'(clock_recovery), 32'(0));
        reset     = 1'b0;
        last_good = '0;
        step(40);
        check("rst_quiet", 32'(data_rec), 32'(0));
        send_frame(14'h0ABC, 1'b1);
        check("post_rst_data", 32'(data_rec), 32'(14'h0ABC));
        check("post_rst_drain", 32'(exp_q.size()), 32'(0));
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
